// File: rtl/rst_sync_seq.sv
// Reset controller: async assert, synchronised release, then staged
// release of NUM_OUT active-low domain resets with soft-reset restart.
module rst_sync_seq #(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_OUT     = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int STEP_CYCLES = 8
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               sw_rst_req,
   output logic [NUM_OUT-1:0] rstn_out,
   output logic               rst_done
);

   localparam int MAXC = (HOLD_CYCLES > STEP_CYCLES) ?
                         HOLD_CYCLES : STEP_CYCLES;
   localparam int CW = $clog2(MAXC) + 1;
   localparam int IW = $clog2(NUM_OUT) + 1;

   typedef enum logic [1:0] {
      HOLD,
      STEP,
      DONE
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [NUM_OUT-1:0]     out_q, out_d;
   logic                   done_q, done_d;
   logic                   hold;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
   end

   assign hold = !sync_q[SYNC_STAGES-1] | sw_rst_req;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      out_d   = out_q;
      done_d  = done_q;
      // Hold condition overrides every state transition
      if (hold) begin
         state_d = HOLD;
         cnt_d   = '0;
         idx_d   = '0;
         out_d   = '0;
         done_d  = 1'b0;
      end else begin
         unique case (state_q)
            HOLD: begin
               if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                  out_d[0] = 1'b1;
                  cnt_d    = '0;
                  idx_d    = IW'(1);
                  if (NUM_OUT == 1) begin
                     done_d  = 1'b1;
                     state_d = DONE;
                  end else begin
                     state_d = STEP;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            STEP: begin
               if (cnt_q == CW'(STEP_CYCLES - 1)) begin
                  for (int i = 0; i < NUM_OUT; i++) begin
                     if (idx_q == IW'(i)) out_d[i] = 1'b1;
                  end
                  cnt_d = '0;
                  idx_d = idx_q + IW'(1);
                  if (idx_q == IW'(NUM_OUT - 1)) begin
                     done_d  = 1'b1;
                     state_d = DONE;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = HOLD;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q  <= '0;
         state_q <= HOLD;
         cnt_q   <= '0;
         idx_q   <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         out_q   <= out_d;
         done_q  <= done_d;
      end
   end

   assign rstn_out = out_q;
   assign rst_done = done_q;

endmodule

// File: tb/tb_rst_sync_seq.sv
// Bench for rst_sync_seq: power-on table, async glitch, soft resets,
// parameter sweep instances and per-cycle invariant checks.
module tb_rst_sync_seq;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       sw = 1'b0;
   logic       sw0 = 1'b0;
   logic [3:0] out4;
   logic       done4;
   logic [0:0] out1;
   logic       done1;
   logic [7:0] out8;
   logic       done8;
   logic [3:0] t4;
   logic [7:0] t8;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;
   int last_l = 2;

   always #5 clk = ~clk;

   rst_sync_seq dut (
      .clk(clk), .rstn(rstn), .sw_rst_req(sw),
      .rstn_out(out4), .rst_done(done4)
   );

   rst_sync_seq #(
      .SYNC_STAGES(3), .NUM_OUT(1), .HOLD_CYCLES(1)
   ) dut1 (
      .clk(clk), .rstn(rstn), .sw_rst_req(sw0),
      .rstn_out(out1), .rst_done(done1)
   );

   rst_sync_seq #(
      .NUM_OUT(8), .STEP_CYCLES(1)
   ) dut8 (
      .clk(clk), .rstn(rstn), .sw_rst_req(sw0),
      .rstn_out(out8), .rst_done(done8)
   );

   typedef struct {
      int         e;
      logic [3:0] o4;
      logic       d4;
      logic       o1;
      logic       d1;
      logic [7:0] o8;
      logic       d8;
   } vec_t;

   typedef struct {
      int         e;
      logic [3:0] o;
      logic       d;
   } exp_t;

   vec_t tbl[15];
   exp_t sbq[$];

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at edge %0d",
                  name, act, exp, edge_n);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      edge_n++;
      #1;
   endtask

   // Closed-form release times relative to last hold edge l
   function automatic exp_t model(input int e, input int l);
      exp_t r;
      r.e = e;
      for (int i = 0; i < 4; i++) r.o[i] = (e >= l + 16 + i * 8);
      r.d = (e >= l + 16 + 3 * 8);
      return r;
   endfunction

   task automatic run_sb(input int n);
      exp_t x;
      for (int k = 0; k < n; k++) begin
         if (sw) last_l = edge_n + 1;
         sbq.push_back(model(edge_n + 1, last_l));
         tick;
         x = sbq.pop_front();
         chk("sb_out", {4'b0, out4}, {4'b0, x.o});
         chk("sb_done", {7'b0, done4}, {7'b0, x.d});
      end
   endtask

   task automatic release_rstn;
      @(negedge clk);
      rstn   = 1'b1;
      edge_n = 0;
      last_l = 2;
   endtask

   task automatic assert_rstn;
      @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("rst_out", {4'b0, out4}, 8'h00);
      chk("rst_done", {7'b0, done4}, 8'h00);
   endtask

   always @(negedge clk) begin
      t4 = out4 + 4'd1;
      t8 = out8 + 8'd1;
      chk("thermo4", {4'b0, t4 & out4}, 8'h00);
      chk("thermo8", t8 & out8, 8'h00);
      chk("done4_inv", {7'b0, done4}, {7'b0, &out4});
      chk("done1_inv", {7'b0, done1}, {7'b0, out1[0]});
      chk("done8_inv", {7'b0, done8}, {7'b0, &out8});
   end

   initial begin
      tbl[0]  = '{1,  4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
      tbl[1]  = '{2,  4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
      tbl[2]  = '{3,  4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
      tbl[3]  = '{4,  4'h0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0};
      tbl[4]  = '{17, 4'h0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0};
      tbl[5]  = '{18, 4'h1, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0};
      tbl[6]  = '{21, 4'h1, 1'b0, 1'b1, 1'b1, 8'h0f, 1'b0};
      tbl[7]  = '{24, 4'h1, 1'b0, 1'b1, 1'b1, 8'h7f, 1'b0};
      tbl[8]  = '{25, 4'h1, 1'b0, 1'b1, 1'b1, 8'hff, 1'b1};
      tbl[9]  = '{26, 4'h3, 1'b0, 1'b1, 1'b1, 8'hff, 1'b1};
      tbl[10] = '{33, 4'h3, 1'b0, 1'b1, 1'b1, 8'hff, 1'b1};
      tbl[11] = '{34, 4'h7, 1'b0, 1'b1, 1'b1, 8'hff, 1'b1};
      tbl[12] = '{41, 4'h7, 1'b0, 1'b1, 1'b1, 8'hff, 1'b1};
      tbl[13] = '{42, 4'hf, 1'b1, 1'b1, 1'b1, 8'hff, 1'b1};
      tbl[14] = '{50, 4'hf, 1'b1, 1'b1, 1'b1, 8'hff, 1'b1};

      #1;
      chk("init_out", {4'b0, out4}, 8'h00);
      chk("init_done", {7'b0, done4}, 8'h00);
      repeat (3) tick;
      chk("low_out4", {4'b0, out4}, 8'h00);
      chk("low_out8", out8, 8'h00);
      chk("low_out1", {7'b0, out1}, 8'h00);

      release_rstn;
      for (int v = 0; v < 15; v++) begin
         while (edge_n < tbl[v].e) tick;
         chk("pwr_out4", {4'b0, out4}, {4'b0, tbl[v].o4});
         chk("pwr_done4", {7'b0, done4}, {7'b0, tbl[v].d4});
         chk("pwr_out1", {7'b0, out1}, {7'b0, tbl[v].o1});
         chk("pwr_done1", {7'b0, done1}, {7'b0, tbl[v].d1});
         chk("pwr_out8", out8, tbl[v].o8);
         chk("pwr_done8", {7'b0, done8}, {7'b0, tbl[v].d8});
      end

      assert_rstn;
      release_rstn;
      run_sb(30);
      #2;
      rstn = 1'b0;
      #1;
      chk("glitch_out4", {4'b0, out4}, 8'h00);
      chk("glitch_done4", {7'b0, done4}, 8'h00);
      chk("glitch_out8", out8, 8'h00);
      #2;
      rstn   = 1'b1;
      edge_n = 0;
      last_l = 2;
      run_sb(99);

      sw = 1'b1;
      run_sb(1);
      sw = 1'b0;
      run_sb(45);

      sw = 1'b1;
      run_sb(20);
      sw = 1'b0;
      run_sb(45);

      assert_rstn;
      release_rstn;
      run_sb(26);
      sw = 1'b1;
      run_sb(3);
      sw = 1'b0;
      run_sb(45);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
